// File: rtl/cnt_run_pkg.sv
// Shared types and constants for the counter run controller.
package cnt_run_pkg;

    // Controller state. Two bits hold three states; the spare encoding recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_t;

    // Default width of the mirror count.
    localparam int unsigned CNT_W_DEFAULT = 4;

endpackage : cnt_run_pkg

// File: rtl/cnt_run_ctrl.sv
// Run controller for an enable-gated counter. It turns start/stop/pause
// commands into enable and count_clr strobes and keeps a mirror count.
// It also detects the terminal count against a live limit. At terminal it
// either stops with a done pulse or wraps and keeps running (auto-restart).
//
// Command priority, highest first: stop, terminal, start, then pause or
// normal counting. The count register and the terminal comparator sit in
// the same next-state process because they share that priority chain.
//
// There is no valid/ready handshake. start and stop are sampled on every
// rising edge and take effect on that edge. pause is a level input that
// gates enable in the same cycle.
module cnt_run_ctrl
    import cnt_run_pkg::*;
#(
    parameter int unsigned N = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         auto_restart,
    input  logic [N-1:0] limit,
    output logic         enable,
    output logic         count_clr,
    output logic         active,
    output logic         done,
    output logic [N-1:0] count,
    output run_state_t   state_dbg
);

    run_state_t   state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         count_clr_q, count_clr_d;
    logic         active_q, active_d;
    logic         done_q, done_d;

    // Counter enable. It is combinational, so a pause edge takes effect in the same cycle.
    assign enable = (state_q == RUN) & ~pause;

    // Next-state, count and strobe logic, applied in command-priority order.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        count_clr_d = 1'b0;
        done_d      = 1'b0;
        if (stop) begin
            state_d     = IDLE;
            count_d     = '0;
            count_clr_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = RUN;
                        count_d     = '0;
                        count_clr_d = 1'b1;
                    end
                end
                RUN: begin
                    // A start request in RUN is ignored on purpose. A paused cycle
                    // does not consume the terminal count.
                    if (enable) begin
                        if (count_q == limit) begin
                            done_d = 1'b1;
                            if (auto_restart) begin
                                // The external counter wraps by itself, so no clear strobe is sent.
                                count_d = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            // Modulo-2^N add. If limit is lowered below count, the count wraps around to reach it.
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_d     = RUN;
                        count_d     = '0;
                        count_clr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
        active_d = (state_d == RUN);
    end

    // State, count and registered strobes. Reset asserts asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            count_clr_q <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            count_clr_q <= count_clr_d;
            active_q    <= active_d;
            done_q      <= done_d;
        end
    end

    assign count_clr = count_clr_q;
    assign active    = active_q;
    assign done      = done_q;
    assign count     = count_q;
    assign state_dbg = state_q;

endmodule : cnt_run_ctrl

// File: tb/tb_cnt_run_ctrl.sv
// Directed bench for cnt_run_ctrl. Inputs change just after each falling
// edge, and outputs are sampled on falling edges. Expected values are
// worked out by hand from the controller's behaviour.
module tb_cnt_run_ctrl;
    import cnt_run_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       pause;
    logic       auto_restart;
    logic [3:0] limit;
    logic       enable;
    logic       count_clr;
    logic       active;
    logic       done;
    logic [3:0] count;
    run_state_t state_dbg;

    int checks = 0;
    int errors = 0;

    cnt_run_ctrl #(.N(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .auto_restart (auto_restart),
        .limit        (limit),
        .enable       (enable),
        .count_clr    (count_clr),
        .active       (active),
        .done         (done),
        .count        (count),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Step to the falling edge where done is seen. n is the number of falling edges taken, or -1 if the budget runs out.
    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 0; stop = 0; pause = 0; auto_restart = 0; limit = 4'd0;
        repeat (3) tick();
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
        checks++; if ({enable, count_clr, active, done, count} !== 8'h00) begin errors++;
            $display("FAIL reset_outputs got en=%b clr=%b act=%b done=%b cnt=%0d exp all 0", enable, count_clr, active, done, count); end
        reset_n = 1'b1;
        tick();
        checks++; if (state_dbg !== IDLE || active !== 1'b0) begin errors++; $display("FAIL reset_release state=%0d act=%b exp IDLE/0", state_dbg, active); end
    endtask

    // limit=5, no pause: count 0..5, one done pulse, then DONE holding 5.
    task automatic test_basic_run();
        limit = 4'd5; auto_restart = 0; pause = 0; start = 1;
        tick(); start = 0;
        checks++; if (active !== 1'b1 || count_clr !== 1'b1 || count !== 4'd0 || enable !== 1'b1) begin errors++;
            $display("FAIL basic_start got act=%b clr=%b cnt=%0d en=%b exp 1/1/0/1", active, count_clr, count, enable); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (count !== i[3:0] || done !== 1'b0 || count_clr !== 1'b0) begin errors++;
                $display("FAIL basic_count got cnt=%0d done=%b clr=%b exp cnt=%0d done=0 clr=0", count, done, count_clr, i); end
        end
        tick();
        checks++; if (done !== 1'b1 || state_dbg !== DONE || count !== 4'd5 || enable !== 1'b0 || active !== 1'b0) begin errors++;
            $display("FAIL basic_terminal got done=%b st=%0d cnt=%0d en=%b act=%b exp 1/DONE/5/0/0", done, state_dbg, count, enable, active); end
        tick();
        checks++; if (done !== 1'b0 || state_dbg !== DONE || count !== 4'd5) begin errors++;
            $display("FAIL basic_done_width got done=%b st=%0d cnt=%0d exp 0/DONE/5", done, state_dbg, count); end
    endtask

    // Same run restarted from DONE, paused for 3 edges at count 2. Done appears 9 falling edges after the start edge instead of 6.
    task automatic test_pause();
        int n;
        start = 1;
        tick(); start = 0;
        checks++; if (state_dbg !== RUN || count !== 4'd0 || count_clr !== 1'b1) begin errors++;
            $display("FAIL pause_restart got st=%0d cnt=%0d clr=%b exp RUN/0/1", state_dbg, count, count_clr); end
        repeat (2) tick();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL pause_pre got cnt=%0d exp 2", count); end
        pause = 1; #1;
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL pause_enable_comb got en=%b exp 0", enable); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (count !== 4'd2 || state_dbg !== RUN || done !== 1'b0) begin errors++;
                $display("FAIL pause_hold got cnt=%0d st=%0d done=%b exp 2/RUN/0", count, state_dbg, done); end
        end
        pause = 0;
        wait_done(10, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL pause_done_delay got edges=%0d exp 4", n); end
        checks++; if (count !== 4'd5 || state_dbg !== DONE) begin errors++; $display("FAIL pause_end got cnt=%0d st=%0d exp 5/DONE", count, state_dbg); end
    endtask

    // limit=3 with auto-restart: the count wraps and done pulses every 4 cycles. Stop arrives on a terminal edge and wins.
    task automatic test_auto_restart();
        logic [3:0] exp_cnt;
        logic       exp_done;
        limit = 4'd3; auto_restart = 1; start = 1;
        tick(); start = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            exp_cnt  = i[3:0] & 4'd3;
            exp_done = (i > 0) && ((i % 4) == 0);
            checks++; if (count !== exp_cnt || done !== exp_done || active !== 1'b1 || state_dbg !== RUN) begin errors++;
                $display("FAIL auto_cycle%0d got cnt=%0d done=%b act=%b exp cnt=%0d done=%b act=1", i, count, done, active, exp_cnt, exp_done); end
            checks++; if (i > 0 && count_clr !== 1'b0) begin errors++; $display("FAIL auto_no_clr cycle%0d got clr=%b exp 0", i, count_clr); end
        end
        stop = 1;
        tick(); stop = 0;
        checks++; if (state_dbg !== IDLE || count !== 4'd0 || count_clr !== 1'b1 || done !== 1'b0 || active !== 1'b0) begin errors++;
            $display("FAIL stop_at_terminal got st=%0d cnt=%0d clr=%b done=%b act=%b exp IDLE/0/1/0/0", state_dbg, count, count_clr, done, active); end
        auto_restart = 0;
    endtask

    // Stop at count 4 with limit 9. Start while in RUN is ignored. Stop beats start when both arrive together.
    task automatic test_stop();
        limit = 4'd9; start = 1;
        tick(); start = 0;
        repeat (4) tick();
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL stop_pre got cnt=%0d exp 4", count); end
        stop = 1;
        tick(); stop = 0;
        checks++; if (state_dbg !== IDLE || count !== 4'd0 || count_clr !== 1'b1 || done !== 1'b0 || active !== 1'b0) begin errors++;
            $display("FAIL stop_run got st=%0d cnt=%0d clr=%b done=%b act=%b exp IDLE/0/1/0/0", state_dbg, count, count_clr, done, active); end
        tick();
        checks++; if (count_clr !== 1'b0 || state_dbg !== IDLE || done !== 1'b0) begin errors++;
            $display("FAIL stop_clr_width got clr=%b st=%0d done=%b exp 0/IDLE/0", count_clr, state_dbg, done); end
        start = 1; stop = 1;
        tick(); start = 0; stop = 0;
        checks++; if (state_dbg !== IDLE || active !== 1'b0) begin errors++; $display("FAIL stop_start_idle got st=%0d act=%b exp IDLE/0", state_dbg, active); end
        start = 1;
        tick(); start = 0;
        tick();
        start = 1;
        tick(); start = 0;
        checks++; if (count !== 4'd2 || count_clr !== 1'b0 || state_dbg !== RUN) begin errors++;
            $display("FAIL start_in_run got cnt=%0d clr=%b st=%0d exp 2/0/RUN", count, count_clr, state_dbg); end
        start = 1; stop = 1;
        tick(); start = 0; stop = 0;
        checks++; if (state_dbg !== IDLE || count !== 4'd0 || active !== 1'b0) begin errors++;
            $display("FAIL stop_start_run got st=%0d cnt=%0d act=%b exp IDLE/0/0", state_dbg, count, active); end
    endtask

    // limit=0: done comes one cycle after active rises. A start in DONE restarts with a clear.
    task automatic test_limit_zero();
        limit = 4'd0; start = 1;
        tick(); start = 0;
        checks++; if (active !== 1'b1 || count !== 4'd0 || done !== 1'b0) begin errors++;
            $display("FAIL lim0_start got act=%b cnt=%0d done=%b exp 1/0/0", active, count, done); end
        tick();
        checks++; if (done !== 1'b1 || state_dbg !== DONE || count !== 4'd0) begin errors++;
            $display("FAIL lim0_done got done=%b st=%0d cnt=%0d exp 1/DONE/0", done, state_dbg, count); end
        start = 1;
        tick(); start = 0;
        checks++; if (state_dbg !== RUN || count !== 4'd0 || count_clr !== 1'b1 || done !== 1'b0) begin errors++;
            $display("FAIL lim0_restart got st=%0d cnt=%0d clr=%b done=%b exp RUN/0/1/0", state_dbg, count, count_clr, done); end
        stop = 1;
        tick(); stop = 0;
    endtask

    // Limit drops from 9 to 2 while count is 5. The count must run through 15, wrap, and reach 2 before done.
    task automatic test_limit_lower();
        logic [3:0] exp_cnt;
        int         k;
        limit = 4'd9; start = 1;
        tick(); start = 0;
        repeat (5) tick();
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL lower_pre got cnt=%0d exp 5", count); end
        limit = 4'd2;
        exp_cnt = 4'd5;
        k = 0;
        while (exp_cnt != 4'd2 && k < 20) begin
            tick();
            exp_cnt = exp_cnt + 4'd1;
            k++;
            checks++; if (count !== exp_cnt || done !== 1'b0) begin errors++;
                $display("FAIL lower_wrap got cnt=%0d done=%b exp cnt=%0d done=0", count, done, exp_cnt); end
        end
        tick();
        checks++; if (done !== 1'b1 || state_dbg !== DONE || count !== 4'd2) begin errors++;
            $display("FAIL lower_done got done=%b st=%0d cnt=%0d exp 1/DONE/2", done, state_dbg, count); end
    endtask

    // Reset is dropped between clock edges and the outputs must clear right away.
    task automatic test_async_reset();
        limit = 4'd9; start = 1;
        tick(); start = 0;
        repeat (2) tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({enable, count_clr, active, done, count} !== 8'h00 || state_dbg !== IDLE) begin errors++;
            $display("FAIL async_reset got en=%b clr=%b act=%b done=%b cnt=%0d st=%0d exp all 0/IDLE", enable, count_clr, active, done, count, state_dbg); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (state_dbg !== IDLE || count !== 4'd0 || active !== 1'b0) begin errors++;
            $display("FAIL async_release got st=%0d cnt=%0d act=%b exp IDLE/0/0", state_dbg, count, active); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_pause();
        test_auto_restart();
        test_stop();
        test_limit_zero();
        test_limit_lower();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cnt_run_ctrl
